gyro_rate_conditioner: RTL and testbench
========================================

// Module: gyro_rate_conditioner
// PURPOSE
//  Per-axis gyro sample conditioner between the 8-channel ADC controller and gyroscope_data_to_degrees.
//  Learns the zero-rate bias by averaging 2**LOG2_CAL samples while the board is at rest.
//  Subtracts the bias, applies a symmetric deadband, and emits a signed rate word with a valid strobe.
//  One instance per axis.
// PARAMETERS
//  DATA_WIDTH  12    raw ADC sample width, unsigned
//  OUT_WIDTH   16    signed rate output width; must be >= DATA_WIDTH+1
//  LOG2_CAL    8     log2 of the calibration sample count (256 samples)
//  DEADBAND    4     |bias-corrected value| <= DEADBAND is forced to 0
//  BIAS_INIT   2048  bias used before the first calibration completes (mid-scale)
// PORTS
//  clk               in   1           system clock, the only clock
//  reset             in   1           synchronous reset, active-high
//  sample_in         in   DATA_WIDTH  raw unsigned ADC sample, already synchronised to clk
//  sample_valid      in   1           1-cycle strobe: sample_in is new this cycle
//  no_external_force in   1           1 = board at rest; calibration accumulates only when high
//  recal             in   1           1-cycle request to restart calibration
//  rate_out          out  OUT_WIDTH   signed, bias-corrected, deadbanded rate
//  rate_valid        out  1           1-cycle strobe: rate_out is updated
//  bias_out          out  DATA_WIDTH  bias currently applied
//  calibrated        out  1           1 = at least one calibration has completed since reset or recal
// BEHAVIOUR
//  Reset (sampled on a clk edge while reset=1) puts the block in state CAL:
//   - rate_out=0, rate_valid=0, bias_out=BIAS_INIT, calibrated=0
//   - acc=0, cnt=0
//  acc is DATA_WIDTH+LOG2_CAL bits wide; cnt is LOG2_CAL+1 bits wide.
//  State CAL (rate_valid held 0; rate_out holds its last value):
//   - sample_valid=1 and no_external_force=1: acc+=sample_in, cnt+=1.
//   - no_external_force=0 in any cycle: acc=0, cnt=0. Partial accumulation is discarded; state stays CAL.
//   - When the sample that makes cnt reach 2**LOG2_CAL is accumulated, on the next cycle:
//     bias_out=acc_final>>LOG2_CAL (truncate), calibrated=1, acc=0, cnt=0, state=RUN.
//  State RUN:
//   - On sample_valid: d = sign-extend(sample_in) - sign-extend(bias_out), computed at OUT_WIDTH.
//     rate_out = (|d| <= DEADBAND) ? 0 : d; rate_valid=1.
//   - Latency is exactly 1 clk from sample_valid to rate_valid. Back-to-back strobes produce back-to-back outputs.
//   - no_external_force is ignored in RUN.
//  recal=1 (any state): next cycle state=CAL, acc=0, cnt=0, calibrated=0, rate_valid=0.
//   - bias_out keeps its previous value until the new calibration completes.
//   - recal wins over a simultaneous sample_valid; that sample is neither output nor accumulated.
//   - recal during CAL restarts the count.
//  reset has priority over recal and everything else.
//  No overflow is possible: acc is sized for 2**LOG2_CAL full-scale samples, and d always fits in DATA_WIDTH+1 signed bits.
//  sample_valid held high for consecutive cycles counts each cycle as a new sample.
// TESTING
//  1. Reset, rest=1, 256 strobes of 2060 -> calibrated rises 1 clk after the 256th strobe; bias_out=2060; no rate_valid before that.
//  2. After test 1, sample 2100 -> 1 clk later rate_valid=1, rate_out=40.
//     Sample 2000 -> rate_out=-60.
//     Samples 2063 and 2056 -> rate_out=0 (within deadband).
//  3. During CAL, drop no_external_force after 100 samples -> cnt restarts.
//     calibrated rises only after 256 further rest samples; bias equals their average.
//  4. In RUN, recal asserted in the same cycle as sample_valid -> no rate_valid.
//     calibrated=0; bias_out unchanged until the recal completes with a new bias.
//  5. Calibration mixing 128x4095 and 128x0 -> bias_out=2047 (truncation check).
//     Then sample 0 -> rate_out=-2047; sample 4095 -> rate_out=2048.
//  6. Assert reset mid-calibration and mid-RUN -> all outputs return to reset values on the next edge.
//     No rate_valid until a new calibration completes.

Source files
------------

// File: rtl/gyro_rate_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : gyro_rate_conditioner
//  Purpose  : Per-axis gyro sample conditioner. Learns the zero-rate bias by
//             averaging 2**LOG2_CAL at-rest samples. It then subtracts the
//             bias from each sample, applies a symmetric deadband, and emits
//             a signed rate word with a one-cycle valid strobe.
//  Ports    : clk               - system clock
//             reset             - synchronous reset, active-high
//             sample_in         - raw unsigned ADC sample
//             sample_valid      - 1-cycle strobe, sample_in is new
//             no_external_force - 1 = board at rest (calibration enabled)
//             recal             - 1-cycle request to restart calibration
//             rate_out          - signed, bias-corrected, deadbanded rate
//             rate_valid        - 1-cycle strobe, rate_out updated
//             bias_out          - bias currently applied
//             calibrated        - a calibration has completed since reset/recal
//  Revision : 1.0 - initial release
// ============================================================================
module gyro_rate_conditioner #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int LOG2_CAL   = 8,
  parameter int DEADBAND   = 4,
  parameter int BIAS_INIT  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  no_external_force,
  input  logic                  recal,
  output logic [OUT_WIDTH-1:0]  rate_out,
  output logic                  rate_valid,
  output logic [DATA_WIDTH-1:0] bias_out,
  output logic                  calibrated
);

  localparam int ACC_W = DATA_WIDTH + LOG2_CAL;
  localparam int CNT_W = LOG2_CAL + 1;

  localparam logic [0:0]       c_st_cal    = 1'b0;
  localparam logic [0:0]       c_st_run    = 1'b1;
  localparam logic [CNT_W-1:0] c_cal_count = CNT_W'(1) << LOG2_CAL;

  logic [0:0]            state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] bias_q, bias_d;
  logic                  cal_q, cal_d;
  logic [OUT_WIDTH-1:0]  rate_q, rate_d;
  logic                  valid_q, valid_d;

  logic [ACC_W-1:0]            w_acc_sum;
  logic [CNT_W-1:0]            w_cnt_sum;
  logic signed [OUT_WIDTH-1:0] w_diff;
  logic [OUT_WIDTH-1:0]        w_mag;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bias_d  = bias_q;
    cal_d   = cal_q;
    rate_d  = rate_q;
    valid_d = 1'b0;

    w_acc_sum = acc_q + ACC_W'(sample_in);
    w_cnt_sum = cnt_q + CNT_W'(1);

    // Both operands are unsigned, so widening with zeros is the sign extension.
    w_diff = $signed(OUT_WIDTH'(sample_in)) - $signed(OUT_WIDTH'(bias_q));
    w_mag  = w_diff[OUT_WIDTH-1] ? OUT_WIDTH'(-w_diff) : OUT_WIDTH'(w_diff);

    if (recal) begin
      // Restart calibration; the previous bias stays applied until the new one lands.
      state_d = c_st_cal;
      acc_d   = '0;
      cnt_d   = '0;
      cal_d   = 1'b0;
    end else if (state_q == c_st_cal) begin
      if (!no_external_force) begin
        // Any motion invalidates the partial average.
        acc_d = '0;
        cnt_d = '0;
      end else if (sample_valid) begin
        if (w_cnt_sum == c_cal_count) begin
          bias_d  = DATA_WIDTH'(w_acc_sum >> LOG2_CAL);
          cal_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = c_st_run;
        end else begin
          acc_d = w_acc_sum;
          cnt_d = w_cnt_sum;
        end
      end
    end else begin
      if (sample_valid) begin
        valid_d = 1'b1;
        rate_d  = (w_mag <= OUT_WIDTH'(DEADBAND)) ? '0 : OUT_WIDTH'(w_diff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_st_cal;
      acc_q   <= '0;
      cnt_q   <= '0;
      bias_q  <= DATA_WIDTH'(BIAS_INIT);
      cal_q   <= 1'b0;
      rate_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bias_q  <= bias_d;
      cal_q   <= cal_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = valid_q;
  assign bias_out   = bias_q;
  assign calibrated = cal_q;

endmodule
`default_nettype wire

// File: tb/tb_gyro_rate_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gyro_rate_conditioner
//  Purpose  : Directed self-checking bench for gyro_rate_conditioner with
//             hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gyro_rate_conditioner;

  logic        clk;
  logic        reset;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        no_external_force;
  logic        recal;
  logic [15:0] rate_out;
  logic        rate_valid;
  logic [11:0] bias_out;
  logic        calibrated;

  int n_checks;
  int n_fail;
  logic saw_valid;
  logic saw_cal;

  gyro_rate_conditioner #(
    .DATA_WIDTH(12), .OUT_WIDTH(16), .LOG2_CAL(8), .DEADBAND(4), .BIAS_INIT(2048)
  ) u_dut (
    .clk               (clk),
    .reset             (reset),
    .sample_in         (sample_in),
    .sample_valid      (sample_valid),
    .no_external_force (no_external_force),
    .recal             (recal),
    .rate_out          (rate_out),
    .rate_valid        (rate_valid),
    .bias_out          (bias_out),
    .calibrated        (calibrated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val);
    sample_in    = 12'(val);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    if (rate_valid) saw_valid = 1'b1;
  endtask

  // Feed n rest samples, noting any rate_valid or calibrated seen on the way.
  task automatic feed(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      send(val);
      if (calibrated) saw_cal = 1'b1;
    end
  endtask

  function automatic int rate_i();
    return int'($signed(rate_out));
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    saw_valid = 1'b0;
    saw_cal   = 1'b0;
    reset = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    no_external_force = 1'b1;
    recal = 1'b0;
    step();
    step();
    reset = 1'b0;

    // ---- 1: reset state and first calibration ----
    check_eq("reset_rate", rate_i(), 0);
    check_eq("reset_valid", int'(rate_valid), 0);
    check_eq("reset_bias", int'(bias_out), 2048);
    check_eq("reset_cal", int'(calibrated), 0);
    feed(2060, 255);
    check_eq("t1_no_early_cal", int'(saw_cal), 0);
    send(2060);
    check_eq("t1_cal", int'(calibrated), 1);
    check_eq("t1_bias", int'(bias_out), 2060);
    check_eq("t1_no_valid_in_cal", int'(saw_valid), 0);

    // ---- 2: running conversion and deadband ----
    send(2100);
    check_eq("t2_valid", int'(rate_valid), 1);
    check_eq("t2_rate_pos", rate_i(), 40);
    step();
    check_eq("t2_valid_pulse", int'(rate_valid), 0);
    send(2000);
    check_eq("t2_rate_neg", rate_i(), -60);
    send(2063);
    check_eq("t2_db_pos", rate_i(), 0);
    send(2056);
    check_eq("t2_db_neg", rate_i(), 0);
    send(2065);
    check_eq("t2_edge_pos", rate_i(), 5);
    send(2055);
    check_eq("t2_b2b_valid", int'(rate_valid), 1);
    check_eq("t2_edge_neg", rate_i(), -5);

    // ---- 3: motion during calibration discards partial sum ----
    recal = 1'b1;
    step();
    recal = 1'b0;
    check_eq("t3_cal_clr", int'(calibrated), 0);
    check_eq("t3_bias_kept", int'(bias_out), 2060);
    saw_cal = 1'b0;
    saw_valid = 1'b0;
    feed(1000, 100);
    no_external_force = 1'b0;
    step();
    no_external_force = 1'b1;
    feed(3000, 128);
    feed(3002, 127);
    check_eq("t3_no_early_cal", int'(saw_cal), 0);
    send(3002);
    check_eq("t3_cal", int'(calibrated), 1);
    check_eq("t3_bias", int'(bias_out), 3001);
    check_eq("t3_no_valid", int'(saw_valid), 0);

    // ---- 4: recal beats simultaneous sample ----
    sample_in = 12'd3100;
    sample_valid = 1'b1;
    recal = 1'b1;
    step();
    sample_valid = 1'b0;
    recal = 1'b0;
    check_eq("t4_no_valid", int'(rate_valid), 0);
    check_eq("t4_cal_clr", int'(calibrated), 0);
    check_eq("t4_bias_kept", int'(bias_out), 3001);

    // ---- 5: truncating average ----
    saw_cal = 1'b0;
    saw_valid = 1'b0;
    feed(4095, 128);
    feed(0, 127);
    check_eq("t5_bias_hold", int'(bias_out), 3001);
    check_eq("t5_no_early_cal", int'(saw_cal), 0);
    send(0);
    check_eq("t5_bias", int'(bias_out), 2047);
    check_eq("t5_cal", int'(calibrated), 1);
    check_eq("t5_no_valid", int'(saw_valid), 0);
    send(0);
    check_eq("t5_rate_min", rate_i(), -2047);
    send(4095);
    check_eq("t5_rate_max", rate_i(), 2048);

    // ---- 6: reset mid-RUN and mid-calibration ----
    reset = 1'b1;
    sample_in = 12'd100;
    sample_valid = 1'b1;
    step();
    reset = 1'b0;
    sample_valid = 1'b0;
    check_eq("t6_run_rate", rate_i(), 0);
    check_eq("t6_run_valid", int'(rate_valid), 0);
    check_eq("t6_run_bias", int'(bias_out), 2048);
    check_eq("t6_run_cal", int'(calibrated), 0);
    saw_valid = 1'b0;
    feed(2500, 50);
    check_eq("t6_cal_no_valid", int'(saw_valid), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t6_mid_bias", int'(bias_out), 2048);
    check_eq("t6_mid_cal", int'(calibrated), 0);
    saw_cal = 1'b0;
    feed(1500, 255);
    check_eq("t6_no_early_cal", int'(saw_cal), 0);
    send(1500);
    check_eq("t6_cal", int'(calibrated), 1);
    check_eq("t6_bias", int'(bias_out), 1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
